// File: rtl/md_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
// The result is formed combinationally from latched operands and committed when the latency counter expires.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES) + 1;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [31:0]   a_reg, a_next;
    logic [31:0]   b_reg, b_next;
    logic [2:0]    op_reg, op_next;
    logic [31:0]   hi_reg, hi_next;
    logic [31:0]   lo_reg, lo_next;
    logic          done_reg, done_next;

    logic [63:0] prod_s, prod_u;
    logic [31:0] abs_a, abs_b, den_s, den_u;
    logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;
    logic        div_zero;
    logic [31:0] res_hi, res_lo;
    logic        commit_en;

    // Result datapath is free-running on latched operands; the counter only decides
    // when it is sampled, so it can be constrained as a multicycle path.
    assign prod_s = $signed({{32{a_reg[31]}}, a_reg}) * $signed({{32{b_reg[31]}}, b_reg});
    assign prod_u = {32'd0, a_reg} * {32'd0, b_reg};

    assign div_zero = (b_reg == 32'd0);
    assign abs_a    = a_reg[31] ? (~a_reg + 32'd1) : a_reg;
    assign abs_b    = b_reg[31] ? (~b_reg + 32'd1) : b_reg;
    assign den_s    = div_zero ? 32'd1 : abs_b;
    assign den_u    = div_zero ? 32'd1 : b_reg;

    // Signed divide via magnitudes: quotient sign is the XOR of operand signs,
    // remainder follows the dividend; 0x80000000 / -1 wraps back to 0x80000000.
    assign q_mag = abs_a / den_s;
    assign r_mag = abs_a % den_s;
    assign q_s   = (a_reg[31] ^ b_reg[31]) ? (~q_mag + 32'd1) : q_mag;
    assign r_s   = a_reg[31] ? (~r_mag + 32'd1) : r_mag;
    assign q_u   = a_reg / den_u;
    assign r_u   = a_reg % den_u;

    always_comb begin
        res_hi    = hi_reg;
        res_lo    = lo_reg;
        commit_en = 1'b0;
        case (op_reg)
            OP_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; commit_en = 1'b1; end
            OP_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; commit_en = 1'b1; end
            OP_DIV:   begin res_hi = r_s; res_lo = q_s; commit_en = !div_zero; end
            OP_DIVU:  begin res_hi = r_u; res_lo = q_u; commit_en = !div_zero; end
            default:  commit_en = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        op_next    = op_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    case (md_op)
                        OP_MULT, OP_MULTU: begin
                            a_next     = src_a;
                            b_next     = src_b;
                            op_next    = md_op;
                            cnt_next   = CW'(MULT_CYCLES);
                            state_next = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            a_next     = src_a;
                            b_next     = src_b;
                            op_next    = md_op;
                            cnt_next   = CW'(DIV_CYCLES);
                            state_next = RUN;
                        end
                        OP_MTHI: hi_next = src_a;
                        OP_MTLO: lo_next = src_a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_next = cnt_reg - CW'(1);
                if (cnt_reg == CW'(1)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                    if (commit_en) begin
                        hi_next = res_hi;
                        lo_next = res_lo;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            op_reg    <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            op_reg    <= op_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
            done_reg  <= done_next;
        end
    end

    assign busy = (state_reg == RUN);
    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed scenarios plus randomized ops against
// an arithmetic reference model of HI/LO.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .src_a (src_a),
        .src_b (src_b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference model: HI/LO after an operation, from plain 64-bit arithmetic.
    task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      x, y, q, r;
        logic [63:0] p, qb, rb;
        case (op)
            3'd1: begin
                x = longint'($signed(a));
                y = longint'($signed(b));
                p = 64'(x * y);
                hi_m = p[63:32];
                lo_m = p[31:0];
            end
            3'd2: begin
                p = {32'd0, a} * {32'd0, b};
                hi_m = p[63:32];
                lo_m = p[31:0];
            end
            3'd3: if (b != 32'd0) begin
                x = longint'($signed(a));
                y = longint'($signed(b));
                q = x / y;
                r = x % y;
                qb = 64'(q);
                rb = 64'(r);
                lo_m = qb[31:0];
                hi_m = rb[31:0];
            end
            3'd4: if (b != 32'd0) begin
                lo_m = a / b;
                hi_m = a % b;
            end
            3'd5: hi_m = a;
            3'd6: lo_m = a;
            default: ;
        endcase
    endtask

    function automatic int latency_of(input logic [2:0] op);
        return (op == 3'd1 || op == 3'd2) ? 5 : 10;
    endfunction

    // Drives one multi-cycle op starting at the current negedge; returns at the negedge
    // after busy falls. glitch flags any HI/LO change or done during busy (vs pre-op model).
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit tamper, output int lat, output bit glitch,
                         output logic d, output logic [31:0] h, output logic [31:0] l);
        start = 1'b1;
        md_op = op;
        src_a = a;
        src_b = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        md_op = 3'd0;
        lat = 0;
        glitch = 1'b0;
        while (busy === 1'b1 && lat < 100) begin
            if (hi !== hi_m || lo !== lo_m || done !== 1'b0) glitch = 1'b1;
            lat++;
            if (tamper) begin
                start = 1'b1;
                md_op = 3'd6;
                src_a = 32'hDEADBEEF;
                src_b = $urandom;
            end else begin
                src_a = $urandom;
                src_b = $urandom;
            end
            @(negedge clk);
        end
        start = 1'b0;
        md_op = 3'd0;
        d = done;
        h = hi;
        l = lo;
        $display("op=%0d a=%08h b=%08h busy_cycles=%0d done=%b hi=%08h lo=%08h", op, a, b, lat, d, h, l);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, hi, lo} !== 66'd0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b done=%b hi=%08h lo=%08h expected all zero", busy, done, hi, lo);
        end
        @(negedge clk);
        reset = 1'b0;
        hi_m = 32'd0;
        lo_m = 32'd0;
        @(negedge clk);
    endtask

    task automatic test_mult();
        int lat; bit gl; logic d; logic [31:0] h, l;
        issue(3'd1, 32'hFFFFFFFE, 32'd3, 1'b0, lat, gl, d, h, l);
        model_op(3'd1, 32'hFFFFFFFE, 32'd3);
        n_checks++; if (lat != 5) begin n_fail++; $display("FAIL mult_latency: got %0d expected 5", lat); end
        n_checks++; if (gl) begin n_fail++; $display("FAIL mult_hold: hi/lo/done changed during busy, expected stable"); end
        n_checks++; if (h !== 32'hFFFFFFFF || l !== 32'hFFFFFFFA) begin
            n_fail++; $display("FAIL mult_result: got hi=%08h lo=%08h expected hi=ffffffff lo=fffffffa", h, l); end
        n_checks++; if (d !== 1'b1) begin n_fail++; $display("FAIL mult_done: got %b expected 1", d); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mult_done_width: got %b expected 0", done); end
    endtask

    task automatic test_multu();
        int lat; bit gl; logic d; logic [31:0] h, l;
        issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, lat, gl, d, h, l);
        model_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        n_checks++; if (lat != 5) begin n_fail++; $display("FAIL multu_latency: got %0d expected 5", lat); end
        n_checks++; if (gl) begin n_fail++; $display("FAIL multu_hold: hi/lo/done changed during busy, expected stable"); end
        n_checks++; if (h !== 32'hFFFFFFFE || l !== 32'h00000001 || d !== 1'b1) begin
            n_fail++; $display("FAIL multu_result: got hi=%08h lo=%08h done=%b expected hi=fffffffe lo=00000001 done=1", h, l, d); end
        @(negedge clk);
    endtask

    task automatic test_div();
        int lat; bit gl; logic d; logic [31:0] h, l;
        issue(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0, lat, gl, d, h, l);
        model_op(3'd3, 32'hFFFFFFF9, 32'd2);
        n_checks++; if (lat != 10) begin n_fail++; $display("FAIL div_latency: got %0d expected 10", lat); end
        n_checks++; if (gl) begin n_fail++; $display("FAIL div_hold: hi/lo/done changed during busy, expected stable"); end
        n_checks++; if (h !== 32'hFFFFFFFF || l !== 32'hFFFFFFFD || d !== 1'b1) begin
            n_fail++; $display("FAIL div_result: got hi=%08h lo=%08h done=%b expected hi=ffffffff lo=fffffffd done=1", h, l, d); end
        @(negedge clk);
        issue(3'd4, 32'd7, 32'd2, 1'b0, lat, gl, d, h, l);
        model_op(3'd4, 32'd7, 32'd2);
        n_checks++; if (lat != 10 || h !== 32'd1 || l !== 32'd3 || d !== 1'b1) begin
            n_fail++; $display("FAIL divu_result: got lat=%0d hi=%08h lo=%08h done=%b expected lat=10 hi=00000001 lo=00000003 done=1", lat, h, l, d); end
        @(negedge clk);
        issue(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, lat, gl, d, h, l);
        model_op(3'd3, 32'h80000000, 32'hFFFFFFFF);
        n_checks++; if (h !== 32'h00000000 || l !== 32'h80000000) begin
            n_fail++; $display("FAIL div_overflow: got hi=%08h lo=%08h expected hi=00000000 lo=80000000", h, l); end
        @(negedge clk);
    endtask

    task automatic test_mt();
        bit busy_seen;
        start = 1'b1; md_op = 3'd5; src_a = 32'h12345678;
        @(posedge clk);
        #1 busy_seen = busy;
        @(negedge clk);
        start = 1'b0; md_op = 3'd0;
        model_op(3'd5, 32'h12345678, 32'd0);
        busy_seen = busy_seen | busy;
        n_checks++; if (busy_seen || hi !== 32'h12345678 || lo !== lo_m) begin
            n_fail++; $display("FAIL mthi: got busy=%b hi=%08h lo=%08h expected busy=0 hi=12345678 lo=%08h", busy_seen, hi, lo, lo_m); end
        $display("op=5 a=12345678 hi=%08h lo=%08h", hi, lo);
        start = 1'b1; md_op = 3'd6; src_a = 32'h9ABCDEF0;
        @(posedge clk);
        #1 busy_seen = busy;
        @(negedge clk);
        start = 1'b0; md_op = 3'd0;
        model_op(3'd6, 32'h9ABCDEF0, 32'd0);
        busy_seen = busy_seen | busy;
        n_checks++; if (busy_seen || hi !== 32'h12345678 || lo !== 32'h9ABCDEF0) begin
            n_fail++; $display("FAIL mtlo: got busy=%b hi=%08h lo=%08h expected busy=0 hi=12345678 lo=9abcdef0", busy_seen, hi, lo); end
        $display("op=6 a=9abcdef0 hi=%08h lo=%08h", hi, lo);
    endtask

    task automatic test_div_zero();
        int lat; bit gl; logic d; logic [31:0] h, l;
        issue(3'd3, 32'h00000055, 32'd0, 1'b0, lat, gl, d, h, l);
        n_checks++; if (lat != 10 || gl || d !== 1'b1) begin
            n_fail++; $display("FAIL div_zero_timing: got lat=%0d glitch=%b done=%b expected lat=10 glitch=0 done=1", lat, gl, d); end
        n_checks++; if (h !== 32'h12345678 || l !== 32'h9ABCDEF0) begin
            n_fail++; $display("FAIL div_zero_hold: got hi=%08h lo=%08h expected hi=12345678 lo=9abcdef0", h, l); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat; bit gl; logic d; logic [31:0] h, l;
        issue(3'd1, 32'h00010003, 32'hFFFF0005, 1'b1, lat, gl, d, h, l);
        model_op(3'd1, 32'h00010003, 32'hFFFF0005);
        n_checks++; if (lat != 5 || gl || d !== 1'b1) begin
            n_fail++; $display("FAIL ignore_timing: got lat=%0d glitch=%b done=%b expected lat=5 glitch=0 done=1", lat, gl, d); end
        n_checks++; if (h !== hi_m || l !== lo_m) begin
            n_fail++; $display("FAIL ignore_result: got hi=%08h lo=%08h expected hi=%08h lo=%08h", h, l, hi_m, lo_m); end
        // Issued in the done cycle: must be accepted without a gap.
        issue(3'd4, 32'hFFFFFFF0, 32'h00000013, 1'b0, lat, gl, d, h, l);
        model_op(3'd4, 32'hFFFFFFF0, 32'h00000013);
        n_checks++; if (lat != 10 || gl || d !== 1'b1 || h !== hi_m || l !== lo_m) begin
            n_fail++; $display("FAIL back_to_back: got lat=%0d glitch=%b done=%b hi=%08h lo=%08h expected lat=10 glitch=0 done=1 hi=%08h lo=%08h",
                               lat, gl, d, h, l, hi_m, lo_m); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_width: got %b expected 0", done); end
    endtask

    task automatic test_random();
        int lat; bit gl; logic d; logic [31:0] h, l;
        logic [2:0] op; logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(0, 7));
            a = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFFFFFF;
                2: b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            if (op >= 3'd1 && op <= 3'd4) begin
                issue(op, a, b, 1'b0, lat, gl, d, h, l);
                model_op(op, a, b);
                n_checks++;
                if (lat != latency_of(op) || gl || d !== 1'b1 || h !== hi_m || l !== lo_m) begin
                    n_fail++;
                    $display("FAIL random_op%0d: got lat=%0d glitch=%b done=%b hi=%08h lo=%08h expected lat=%0d glitch=0 done=1 hi=%08h lo=%08h",
                             op, lat, gl, d, h, l, latency_of(op), hi_m, lo_m);
                end
            end else begin
                start = 1'b1; md_op = op; src_a = a; src_b = b;
                @(posedge clk);
                @(negedge clk);
                start = 1'b0; md_op = 3'd0;
                model_op(op, a, b);
                $display("op=%0d a=%08h b=%08h busy=%b hi=%08h lo=%08h", op, a, b, busy, hi, lo);
                n_checks++;
                if (busy !== 1'b0 || done !== 1'b0 || hi !== hi_m || lo !== lo_m) begin
                    n_fail++;
                    $display("FAIL random_op%0d: got busy=%b done=%b hi=%08h lo=%08h expected busy=0 done=0 hi=%08h lo=%08h",
                             op, busy, done, hi, lo, hi_m, lo_m);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        bit seen;
        start = 1'b1; md_op = 3'd5; src_a = 32'hA5A5A5A5;
        @(negedge clk);
        md_op = 3'd6; src_a = 32'h5A5A5A5A;
        @(negedge clk);
        md_op = 3'd3; src_a = 32'hFFFFFF9C; src_b = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; md_op = 3'd0;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b1 || hi !== 32'hA5A5A5A5) begin
            n_fail++; $display("FAIL areset_pre: got busy=%b hi=%08h expected busy=1 hi=a5a5a5a5", busy, hi); end
        #1 reset = 1'b1;
        #1;
        $display("async reset mid-run: busy=%b hi=%08h lo=%08h", busy, hi, lo);
        n_checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || done !== 1'b0) begin
            n_fail++; $display("FAIL areset_immediate: got busy=%b done=%b hi=%08h lo=%08h expected all zero", busy, done, hi, lo); end
        @(negedge clk);
        reset = 1'b0;
        hi_m = 32'd0;
        lo_m = 32'd0;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || hi !== hi_m || lo !== lo_m) seen = 1'b1;
        end
        n_checks++; if (seen) begin n_fail++; $display("FAIL areset_no_done: got activity after abort expected none"); end
    endtask

    initial begin
        #2;
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_mt();
        test_div_zero();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/md_unit.md
# md_unit

Multi-cycle multiply/divide unit with HI/LO registers, sitting directly downstream of the register-file read ports alongside the ALU. It consumes the rs/rt operands and a decoded operation from the controller. It runs MULT/MULTU/DIV/DIVU over a fixed number of cycles and holds results in HI/LO for MFHI/MFLO write-back. While an operation is in flight it raises `busy` so the controller can stall dependent instructions.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: cycles `busy` stays high for MULT/MULTU (must be ≥1).
- `DIV_CYCLES`, default 10: cycles `busy` stays high for DIV/DIVU (must be ≥1).

Ports:
- `clk`  in  1: single clock; all state changes on rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: operation request, qualifies `md_op`.
- `md_op`  in  3: 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 0 and 7 are no-ops.
- `src_a`  in  32: rs value (multiplicand/dividend; MTHI/MTLO data).
- `src_b`  in  32: rt value (multiplier/divisor).
- `busy`  out  1: operation in flight; HI/LO not yet valid.
- `done`  out  1: one-cycle pulse in the cycle after HI/LO are updated by MULT/DIV.
- `hi`  out  32: HI register.
- `lo`  out  32: LO register.

## Operation
- States: IDLE, RUN. Internal registers: latched operands, latched op, down-counter `cnt` (width ≥ clog2(max latency)+1).
- IDLE, `start`=1, op in 1..4: latch `src_a`, `src_b`, and op. Load `cnt` with MULT_CYCLES or DIV_CYCLES. Go to RUN.
- IDLE, `start`=1, op 5/6: write `src_a` into HI (5) or LO (6) at that edge. Stay IDLE; `busy` not raised.
- IDLE, `start`=0 or op 0/7: no change.
- RUN: `cnt` decrements each edge. At the edge where `cnt`==1:
  - commit the result to HI/LO;
  - return to IDLE;
  - set `done` for the following cycle.
- Any `start` while in RUN is ignored, including MTHI/MTLO. The controller must stall instead.
- MULT: signed 32×32 → 64-bit product; HI = [63:32], LO = [31:0].
- MULTU: the same product computed unsigned.
- DIV (signed):
  - LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0x00000000.
- DIVU: unsigned quotient into LO, unsigned remainder into HI.
- Divide by zero (DIV or DIVU): the unit still runs the full DIV_CYCLES with `busy` high and still pulses `done`. HI and LO are left unchanged.
- Results are computed from the latched operands. Changing `src_a`/`src_b` during RUN has no effect.
- Implementation may be iterative or combinational-plus-delay. The externally visible latency is fixed by the parameters.

## Timing
- Reset (asynchronous, takes effect immediately):
  - `hi`=0, `lo`=0, `busy`=0, `done`=0;
  - state IDLE, `cnt`=0.
- `busy` is registered. It goes high in the cycle after the accepting edge and stays high for exactly MULT_CYCLES or DIV_CYCLES cycles.
- `hi`/`lo` keep their old values throughout RUN. They change at the same edge that drops `busy`.
- `done` is high for exactly one cycle, coincident with the first cycle of `busy`=0 after RUN.
- Back-to-back operation: `start` may be accepted in the very cycle `done` is high, because `busy` is already 0.
- MTHI/MTLO take effect at the accepting edge, so `hi`/`lo` show the new value in the next cycle.
- Reset asserted mid-RUN aborts the operation. HI/LO are forced to 0 and no `done` is produced.
- All outputs come straight from registers; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then MULT with `src_a`=0xFFFFFFFE (-2) and `src_b`=3. Required:
  - `busy` high for 5 cycles;
  - then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA;
  - `done` pulses once.
- MULTU with 0xFFFFFFFF × 0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001 after 5 busy cycles.
- DIV with -7 / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF after 10 busy cycles. Then DIVU 7/2 → `lo`=3, `hi`=1.
- MTHI 0x12345678, then MTLO 0x9ABCDEF0. Required:
  - `busy` never rises;
  - `hi`/`lo` hold those values one cycle after each write.
  - Then DIV x/0 → `busy` 10 cycles, `hi`/`lo` unchanged, `done` pulses.
- MULT accepted, then during RUN assert `start` with MTLO 0xDEADBEEF and toggle the operands. Required:
  - the MTLO is ignored;
  - the result matches the originally latched operands.
  - A new DIVU issued in the `done` cycle is accepted.
- Start a DIV, assert `reset` asynchronously at busy cycle 4 (between clock edges). Required:
  - `busy`, `hi`, `lo` go to 0 immediately;
  - no `done` pulse follows.
